// File: rtl/mdr_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared CPU datapath definitions.
//   DATA_W    - width of a CPU data word
//   word_t    - one data word
//   ZERO_WORD - all-zero word, the cleared / gated-off value
// Optional build macro used by this slice: MDR_TRISTATE_OUT_EN (see mdr_out_gate).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t ZERO_WORD = '0;

endpackage : cpu_pkg

// File: rtl/mdr_if.sv
// ---------------------------------------------------------------------------
// mdr_if: bus/memory side signals of the Memory Data Register.
//   in_bus_en  - load the stored word from bus_in
//   in_mem_en  - load the stored word from mem_in (wins over in_bus_en)
//   out_bus_en - drive the stored word onto bus_out
//   out_mem_en - drive the stored word onto mem_out
//   bus_in / bus_out - CPU bus data in / out
//   mem_in / mem_out - memory data in / out
// Modports: master (the CPU/memory side driving the controls and inputs),
//           slave  (the MDR itself).
// ---------------------------------------------------------------------------
interface mdr_if #(
    parameter int WIDTH = cpu_pkg::DATA_W
);
    logic             in_bus_en;
    logic             in_mem_en;
    logic             out_bus_en;
    logic             out_mem_en;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] mem_in;
    logic [WIDTH-1:0] mem_out;

    modport master (
        output in_bus_en,
        output in_mem_en,
        output out_bus_en,
        output out_mem_en,
        output bus_in,
        output mem_in,
        input  bus_out,
        input  mem_out
    );

    modport slave (
        input  in_bus_en,
        input  in_mem_en,
        input  out_bus_en,
        input  out_mem_en,
        input  bus_in,
        input  mem_in,
        output bus_out,
        output mem_out
    );
endinterface : mdr_if

// File: rtl/mdr_out_gate.sv
// ---------------------------------------------------------------------------
// mdr_out_gate: combinational output gate for the stored MDR word.
//   i_en   - output enable
//   i_q    - stored word
//   o_data - i_q when enabled; otherwise all zeros, or all Z when the
//            MDR_TRISTATE_OUT_EN macro is defined (lets bus_out share a bus).
// No register here: the enabled output follows the stored word with no
// added latency.
// ---------------------------------------------------------------------------
module mdr_out_gate
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_data
);

`ifdef MDR_TRISTATE_OUT_EN
    // Release the line when disabled. While reset is asserted the stored word
    // is zero, so an enabled gate drives 0 rather than floating.
    assign o_data = i_en ? i_q : {WIDTH{1'bz}};
`else
    assign o_data = i_en ? i_q : {WIDTH{1'b0}};
`endif

endmodule : mdr_out_gate

// File: rtl/mdr.sv
// ---------------------------------------------------------------------------
// mdr: Memory Data Register between the CPU internal bus and the memory
// data port.
//   clk   - system clock, loads on the rising edge
//   reset - asynchronous active-low reset, clears the stored word at once
//   bus   - mdr_if.slave: load enables, output enables, bus/memory data
// Behaviour: one WIDTH-bit register. Memory load has priority over bus load;
// with neither enable the word holds. Both outputs are gated copies of the
// stored word (never of the data inputs), so a cycle that loads and drives
// shows the old word until the edge and the new word after it.
// Optional build macro: MDR_TRISTATE_OUT_EN - disabled outputs float (Z)
// instead of driving zero.
// ---------------------------------------------------------------------------
module mdr
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic  clk,
    input  logic  reset,
    mdr_if.slave  bus
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Memory side has priority when both load enables are raised.
    always_comb begin
        w_q_next = r_q;
        if (bus.in_mem_en) begin
            w_q_next = bus.mem_in;
        end else if (bus.in_bus_en) begin
            w_q_next = bus.bus_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= WIDTH'(ZERO_WORD);
        end else begin
            r_q <= w_q_next;
        end
    end

    mdr_out_gate #(.WIDTH(WIDTH)) u_bus_gate (
        .i_en   (bus.out_bus_en),
        .i_q    (r_q),
        .o_data (bus.bus_out)
    );

    mdr_out_gate #(.WIDTH(WIDTH)) u_mem_gate (
        .i_en   (bus.out_mem_en),
        .i_q    (r_q),
        .o_data (bus.mem_out)
    );

endmodule : mdr

// File: tb/tb_mdr.sv
// ---------------------------------------------------------------------------
// tb_mdr: self-checking bench for mdr. A table of directed vectors is
// applied one per clock; each vector is checked just before and just after
// its rising edge. Hand-written sequences cover asynchronous reset between
// edges and reset held across a loading edge.
// ---------------------------------------------------------------------------
module tb_mdr;

    localparam int W = 16;

`ifdef MDR_TRISTATE_OUT_EN
    localparam logic [W-1:0] DIS = {W{1'bz}};
`else
    localparam logic [W-1:0] DIS = '0;
`endif

    typedef struct {
        logic         ibe;
        logic         ime;
        logic         obe;
        logic         ome;
        logic [W-1:0] bin;
        logic [W-1:0] min;
        logic [W-1:0] pre_bus;
        logic [W-1:0] pre_mem;
        logic [W-1:0] post_bus;
        logic [W-1:0] post_mem;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdr_if #(.WIDTH(W)) mif ();

    mdr #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ibe, input logic ime, input logic obe,
                         input logic ome, input logic [W-1:0] bin,
                         input logic [W-1:0] min);
        mif.in_bus_en  = ibe;
        mif.in_mem_en  = ime;
        mif.out_bus_en = obe;
        mif.out_mem_en = ome;
        mif.bus_in     = bin;
        mif.mem_in     = min;
    endtask

    vec_t vecs[12];

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);

        // q starts at 0 (reset after q was 0): bus load, read, memory load
        // with simultaneous drive, priority, cross-port load, hold, read.
        //           ibe   ime   obe   ome   bus_in    mem_in    pre_bus   pre_mem   post_bus  post_mem
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, DIS,      DIS,      DIS,      DIS     };
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, DIS,      16'h0001, DIS     };
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h000F, 16'h0001, 16'h0001, 16'h000F, 16'h000F};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00AA, 16'h0055, 16'h000F, 16'h000F, 16'h0055, 16'h0055};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h9999, DIS,      16'h0055, DIS,      16'h1234};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF, DIS,      DIS,      DIS,      DIS     };
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, DIS,      DIS,      DIS,      DIS     };
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 16'hA5A5, DIS,      DIS,      DIS,      DIS     };
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0, DIS,      DIS,      DIS,      DIS     };
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h8888, DIS,      DIS,      DIS,      DIS     };
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h4444, 16'h3333, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h1234, DIS,      16'hBEEF, DIS     };

        // Reset state with both outputs enabled.
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus_out", mif.bus_out, 16'h0000);
        check("reset_mem_out", mif.mem_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].ibe, vecs[i].ime, vecs[i].obe, vecs[i].ome,
                  vecs[i].bin, vecs[i].min);
            #2;
            check($sformatf("vec%0d_pre_bus", i), mif.bus_out, vecs[i].pre_bus);
            check($sformatf("vec%0d_pre_mem", i), mif.mem_out, vecs[i].pre_mem);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_post_bus", i), mif.bus_out, vecs[i].post_bus);
            check($sformatf("vec%0d_post_mem", i), mif.mem_out, vecs[i].post_mem);
            $display("vec %0d: ibe=%b ime=%b obe=%b ome=%b bus_in=%h mem_in=%h -> bus_out=%h mem_out=%h",
                     i, vecs[i].ibe, vecs[i].ime, vecs[i].obe, vecs[i].ome,
                     vecs[i].bin, vecs[i].min, mif.bus_out, mif.mem_out);
        end

        // q is now 0xBEEF. Short reset pulse between edges clears q at once.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        #1;
        check("pulse_pre_bus", mif.bus_out, 16'hBEEF);
        reset = 1'b0;
        #1;
        check("pulse_bus_out", mif.bus_out, 16'h0000);
        check("pulse_mem_out", mif.mem_out, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("pulse_after_edge", mif.bus_out, 16'h0000);
        $display("seq reset_pulse: bus_out=%h mem_out=%h", mif.bus_out, mif.mem_out);

        // Reset held low across a loading edge: load ignored until release.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_load_bus", mif.bus_out, 16'h0000);
        check("rst_load_mem", mif.mem_out, 16'h0000);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_release_pre", mif.bus_out, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_release_bus", mif.bus_out, 16'hFFFF);
        check("rst_release_mem", mif.mem_out, 16'hFFFF);
        $display("seq reset_across_load: bus_out=%h mem_out=%h", mif.bus_out, mif.mem_out);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mdr

// File: doc/mdr.md
Name: mdr

Overview:
- 16-bit Memory Data Register sitting between the CPU internal bus and the memory data port.
- Captures a word from either the bus or memory on a clock edge, holds it, and presents it to the bus and/or memory under independent output enables.
- Memory-side and bus-side transfers are independent, so one cycle can both load a new word and drive the old one.

Parameters:
- WIDTH, 16, data word width for all data ports and the storage register.

Ports:
- clk  input  1  system clock; all loads occur on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears the stored word.
- in_bus_en  input  1  load the stored word from bus_in at the next rising edge.
- in_mem_en  input  1  load the stored word from mem_in at the next rising edge.
- out_bus_en  input  1  drive the stored word onto bus_out.
- out_mem_en  input  1  drive the stored word onto mem_out.
- bus_in  input  WIDTH  data from the CPU bus.
- bus_out  output  WIDTH  data to the CPU bus.
- mem_in  input  WIDTH  data from memory.
- mem_out  output  WIDTH  data to memory.

Behaviour:
- Storage: one WIDTH-bit register q.
- Reset: reset low clears q to 0 immediately, with no clock needed.
  - While reset is held low, q stays 0 and all loads are ignored.
  - Release takes effect asynchronously; the first load can happen on the first rising edge after release.
- Load, at the rising edge with reset high:
  - in_mem_en=1 → q <= mem_in.
  - else in_bus_en=1 → q <= bus_in.
  - else q holds.
  - Both load enables high: mem_in wins (memory has priority).
- Output path is combinational from q, with no extra latency:
  - bus_out = out_bus_en ? q : 0.
  - mem_out = out_mem_en ? q : 0.
- Read-before-write: in a cycle where a load and an output enable are both active, the outputs show the old q until the edge, then the new q.
- Load latency is 1 cycle: a value presented at edge N appears on enabled outputs right after edge N.
- Input enables and output enables are fully independent; any combination is legal.
- Reset mid-operation: outputs that are enabled drop to 0 as soon as reset goes low.
- Data inputs are never passed straight through to the outputs (no bypass).

Optional Feature:
- Macro MDR_TRISTATE_OUT_EN.
- Defined: disabled outputs drive high-impedance (all Z) instead of 0, so bus_out can share a common bus. During reset, enabled outputs drive 0.
- Undefined (default): disabled outputs drive 0, as described in Behaviour.

Decomposition:
- Shared package cpu_pkg:
  - constant DATA_W = 16.
  - typedef word_t (logic [DATA_W-1:0]).
  - The zero-word constant.
- Sub-module: mdr_out_gate, instantiated twice (once for bus_out, once for mem_out).
  - Takes an enable and q, drives the gated word.
  - Handles the MDR_TRISTATE_OUT_EN variant.

Test Plan:
- Reset: set q nonzero, pulse reset low for 1 ns between clock edges → q=0 immediately; with both output enables high, bus_out=0 and mem_out=0 at once.
- Bus load: bus_in=1, in_bus_en=1 for one edge, then out_bus_en=1 → bus_out=1; mem_out=0 while out_mem_en=0.
- Memory load with simultaneous drive: q=1, mem_in=15, in_mem_en=1, out_bus_en=1, out_mem_en=1:
  - before the edge, bus_out=1 and mem_out=1;
  - after the edge, both equal 15.
- Priority: bus_in=0x00AA, mem_in=0x0055, both load enables high → q=0x0055 after the edge.
- Hold: all enables low for 5 cycles after q=0x1234 with changing inputs → q stays 0x1234; both outputs read 0 (Z with MDR_TRISTATE_OUT_EN).
- Reset during a load: reset low across a rising edge with in_bus_en=1, bus_in=0xFFFF → q stays 0 until release; the next edge loads 0xFFFF.
